// File: rtl/uart_tx.sv
// uart_tx: 8E1/8O1 UART transmitter, bit timing shared with uart_rx.
// Frame: START(0), DATA[0..7] LSB first, PARITY, STOP(1); each bit lasts 2*BAUD_RATE clocks.
// Optional build macro UART_TX_FIFO_EN adds a 4-entry input FIFO ahead of the FSM;
// without it a single transfer is in flight and tx_ready drops until the last stop cycle.

`ifndef BAUD6M_CLK48M
`define BAUD6M_CLK48M 4
`endif

module uart_tx #(
  parameter int unsigned BAUD_RATE = `BAUD6M_CLK48M,  // half-bit period in clk cycles
  parameter bit          PARITY    = 1'b0             // 0 = even, 1 = odd
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] data_to_send,
  output logic       tx,
  output logic       tx_ready,
  output logic       tx_done,
  output logic [2:0] curr_state
);

  localparam int unsigned BitCycles = 2 * BAUD_RATE;
  localparam int unsigned CntW      = (BitCycles > 1) ? $clog2(BitCycles) : 1;
  localparam logic [CntW-1:0] CntLast   = CntW'(BitCycles - 1);
  localparam logic [CntW-1:0] CntPenult = CntW'(BitCycles - 2);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] bit_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [8:0]      shift_q;   // {parity, data}; bit 0 is the next bit to drive
  logic            tx_q;
  logic            done_q;
  logic            ready_q;

  logic            bit_end;
  logic            stop_last;
  logic            load;
  logic [7:0]      load_data;
  logic            load_par;

  assign bit_end   = (bit_cnt_q == CntLast);
  assign stop_last = (state_q == StStop) && bit_end;

`ifdef UART_TX_FIFO_EN

  logic [7:0] fifo_mem_q [4];
  logic [1:0] wr_ptr_q;
  logic [1:0] rd_ptr_q;
  logic [2:0] count_q;
  logic [2:0] count_d;
  logic       push;
  logic       pop;

  assign push = tx_start && ready_q;
  // The FSM takes a byte whenever it would otherwise idle, including the
  // last stop cycle so queued frames go out back-to-back.
  assign pop  = ((state_q == StIdle) || stop_last) && (count_q != 3'd0);

  // Occupancy follows push/pop; simultaneous push and pop leaves it unchanged
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, pointers and the registered not-full flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        fifo_mem_q[i] <= 8'h00;
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      ready_q  <= 1'b1;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= data_to_send;
        wr_ptr_q             <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      count_q <= count_d;
      ready_q <= (count_d != 3'd4);
    end
  end

  assign load      = pop;
  assign load_data = fifo_mem_q[rd_ptr_q];

`else

  // ready_q is only high in IDLE or the last stop cycle, so this is always a
  // legal point to start a frame.
  assign load      = tx_start && ready_q;
  assign load_data = data_to_send;

`endif

  assign load_par = (^load_data) ^ PARITY;

  // Frame sequencer: bit timing, shifting and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 9'd0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
`ifndef UART_TX_FIFO_EN
      ready_q   <= 1'b1;
`endif
    end else begin
      done_q <= 1'b0;
      if (load) begin
        // Start bit goes on the line the cycle after the byte is taken
        state_q   <= StStart;
        bit_cnt_q <= '0;
        bit_idx_q <= 3'd0;
        shift_q   <= {load_par, load_data};
        tx_q      <= 1'b0;
`ifndef UART_TX_FIFO_EN
        ready_q   <= 1'b0;
`endif
      end else begin
        case (state_q)
          StIdle: begin
            tx_q      <= 1'b1;
            bit_cnt_q <= '0;
          end
          StStart: begin
            if (bit_end) begin
              bit_cnt_q <= '0;
              bit_idx_q <= 3'd0;
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              state_q   <= StData;
            end else begin
              bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
          end
          StData: begin
            if (bit_end) begin
              bit_cnt_q <= '0;
              // After the eighth data bit the shifter presents the parity bit
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              if (bit_idx_q == 3'd7) begin
                state_q <= StParity;
              end else begin
                bit_idx_q <= bit_idx_q + 3'd1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
          end
          StParity: begin
            if (bit_end) begin
              bit_cnt_q <= '0;
              tx_q      <= 1'b1;
              state_q   <= StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
          end
          StStop: begin
            if (bit_end) begin
              bit_cnt_q <= '0;
              tx_q      <= 1'b1;
              state_q   <= StIdle;
            end else begin
              bit_cnt_q <= bit_cnt_q + CntW'(1);
              // Entering the final stop cycle: flag completion and reopen the
              // handshake so the next frame can follow with no idle gap.
              if (bit_cnt_q == CntPenult) begin
                done_q  <= 1'b1;
`ifndef UART_TX_FIFO_EN
                ready_q <= 1'b1;
`endif
              end
            end
          end
          default: begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
          end
        endcase
      end
    end
  end

  assign tx         = tx_q;
  assign tx_ready   = ready_q;
  assign tx_done    = done_q;
  assign curr_state = state_q;

  // tx_done is a stop-bit event: line high, FSM in STOP, single-cycle pulse
  assert property (@(posedge clk) disable iff (reset) tx_done |-> (state_q == StStop) && tx);
  assert property (@(posedge clk) disable iff (reset) tx_done |=> !tx_done);

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx at BAUD_RATE=4 (8 clk/bit, 88 clk/frame). Two instances share the
// inputs, one even and one odd parity. A frame-level reference model predicts the line,
// handshake, done pulse and state every cycle; a vector table pins explicit frames.
// Honours UART_TX_FIFO_EN the same way the design does.

module tb_uart_tx;

  localparam int BitCyc   = 8;
  localparam int FrameCyc = 11 * BitCyc;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic [7:0] data;
  logic       tx0, rdy0, done0;
  logic [2:0] st0;
  logic       tx1, rdy1, done1;
  logic [2:0] st1;

  uart_tx #(.BAUD_RATE(4), .PARITY(1'b0)) dut_even (
    .clk(clk), .reset(reset), .tx_start(tx_start), .data_to_send(data),
    .tx(tx0), .tx_ready(rdy0), .tx_done(done0), .curr_state(st0)
  );

  uart_tx #(.BAUD_RATE(4), .PARITY(1'b1)) dut_odd (
    .clk(clk), .reset(reset), .tx_start(tx_start), .data_to_send(data),
    .tx(tx1), .tx_ready(rdy1), .tx_done(done1), .curr_state(st1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  // Reference model: is a frame on the line, which cycle of it, which byte, pending bytes
  logic       m_active = 1'b0;
  int         m_n = 0;
  logic [7:0] m_cur = 8'h00;
  logic [7:0] m_q[$];
  logic       last_acc = 1'b0;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] line;     // even-parity frame, MSB = start bit
    logic        par_odd;  // parity bit when PARITY=1
  } vec_t;

  vec_t vecs[8];

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input logic odd, input int k);
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[k-1];
    else if (k == 9) return (^b) ^ odd;
    else return 1'b1;
  endfunction

  function automatic logic m_ready();
`ifdef UART_TX_FIFO_EN
    return m_q.size() < 4;
`else
    return !m_active || (m_n == FrameCyc - 1);
`endif
  endfunction

  function automatic int m_state();
    int k;
    if (!m_active) return 0;
    k = m_n / BitCyc;
    if (k == 0) return 1;
    else if (k <= 8) return 2;
    else if (k == 9) return 3;
    else return 4;
  endfunction

  task automatic check_outputs();
    int   k;
    logic e0, e1, ed;
    k  = m_n / BitCyc;
    e0 = m_active ? frame_bit(m_cur, 1'b0, k) : 1'b1;
    e1 = m_active ? frame_bit(m_cur, 1'b1, k) : 1'b1;
    ed = m_active && (m_n == FrameCyc - 1);
    chk_bit("tx_even", tx0, e0);
    chk_bit("tx_odd", tx1, e1);
    chk_bit("tx_ready", rdy0, m_ready());
    chk_bit("tx_done", done0, ed);
    chk_bit("tx_done_odd", done1, ed);
    chk_int("curr_state", int'(st0), m_state());
    if (done0 === 1'b1) done_seen++;
  endtask

  // One clock: advance the model across the coming edge, then check at the negedge
  task automatic tick();
    logic       acc, last, pop;
    logic [7:0] pv;
    acc  = tx_start && m_ready() && !reset;
    last = m_active && (m_n == FrameCyc - 1);
    pv   = 8'h00;
    pop  = 1'b0;
    last_acc = acc;
`ifdef UART_TX_FIFO_EN
    pop = (!m_active || last) && (m_q.size() > 0) && !reset;
    if (pop) pv = m_q.pop_front();
    if (acc) m_q.push_back(data);
`else
    pop = acc;
    pv  = data;
`endif
    if (!reset) begin
      if (pop) begin
        m_active = 1'b1;
        m_n      = 0;
        m_cur    = pv;
      end else if (m_active) begin
        if (last) m_active = 1'b0;
        else m_n++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((m_active || m_q.size() > 0) && t < 400) begin
      tick();
      t++;
    end
    chk_int("idle_within_budget", (t < 400) ? 1 : 0, 1);
  endtask

  task automatic send(input logic [7:0] b);
    tx_start = 1'b1;
    data     = b;
    tick();
    tx_start = 1'b0;
    data     = 8'($urandom);
  endtask

  // Sends one table entry and compares mid-bit samples against the stored frame
  task automatic run_vector(input vec_t v);
    int   t, d0;
    logic e1;
    wait_idle();
    d0 = done_seen;
    send(v.data);
    t = 0;
    while (!m_active && t < 4) begin
      tick();
      t++;
    end
    for (int k = 0; k < FrameCyc; k++) begin
      if (k % BitCyc == BitCyc / 2) begin
        e1 = (k / BitCyc == 9) ? v.par_odd : v.line[10 - k / BitCyc];
        chk_bit("vec_line_even", tx0, v.line[10 - k / BitCyc]);
        chk_bit("vec_line_odd", tx1, e1);
      end
      data = 8'($urandom);  // must not disturb the frame in flight
      tick();
    end
    chk_int("vec_done_pulses", done_seen - d0, 1);
  endtask

  initial begin
    int d0, nxt, acc_cnt;

    vecs[0] = '{8'hA5, 11'b0_10100101_0_1, 1'b1};
    vecs[1] = '{8'h00, 11'b0_00000000_0_1, 1'b1};
    vecs[2] = '{8'hFF, 11'b0_11111111_0_1, 1'b1};
    vecs[3] = '{8'h01, 11'b0_10000000_1_1, 1'b0};
    vecs[4] = '{8'h80, 11'b0_00000001_1_1, 1'b0};
    vecs[5] = '{8'h3C, 11'b0_00111100_0_1, 1'b1};
    vecs[6] = '{8'h07, 11'b0_11100000_1_1, 1'b0};
    vecs[7] = '{8'h81, 11'b0_10000001_0_1, 1'b1};

    // Reset and a quiet line
    reset    = 1'b1;
    tx_start = 1'b0;
    data     = 8'h00;
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b0;
    repeat (200) tick();
    chk_int("idle_no_done", done_seen, 0);

    // Explicit frames, both parity senses
    for (int i = 0; i < 8; i++) run_vector(vecs[i]);

    // Request mid-frame while busy
    wait_idle();
    d0 = done_seen;
    send(8'h5A);
    repeat (20) tick();
    tx_start = 1'b1;
    data     = 8'h3C;
    tick();
    tx_start = 1'b0;
    repeat (200) tick();
`ifdef UART_TX_FIFO_EN
    chk_int("busy_request_frames", done_seen - d0, 2);
`else
    chk_int("busy_request_frames", done_seen - d0, 1);
`endif

    // Asynchronous reset during data bit 3 abandons the frame
    wait_idle();
    send(8'h81);
    repeat (34) tick();
    #2 reset = 1'b1;
    #1;
    m_active = 1'b0;
    m_q.delete();
    chk_bit("async_reset_tx", tx0, 1'b1);
    chk_bit("async_reset_ready", rdy0, 1'b1);
    chk_int("async_reset_state", int'(st0), 0);
    d0 = done_seen;
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    chk_int("abort_no_done", done_seen - d0, 0);
    run_vector(vecs[7]);

    // Back-to-back 0x00..0x3F with the request held high
    wait_idle();
    d0  = done_seen;
    nxt = 0;
    for (int c = 0; c < 64 * FrameCyc + 500 && nxt < 64; c++) begin
      tx_start = 1'b1;
      data     = 8'(nxt);
      tick();
      if (last_acc) nxt++;
    end
    tx_start = 1'b0;
    wait_idle();
    chk_int("b2b_accepts", nxt, 64);
    chk_int("b2b_done_pulses", done_seen - d0, 64);

`ifdef UART_TX_FIFO_EN
    // Held request with changing data fills the FIFO after five accepts
    wait_idle();
    acc_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tx_start = 1'b1;
      data     = 8'h11 + 8'(i);
      if (rdy0 === 1'b1) acc_cnt++;
      tick();
    end
    tx_start = 1'b0;
    chk_int("fifo_accepts", acc_cnt, 5);
    chk_bit("fifo_full_ready", rdy0, 1'b0);
    wait_idle();
    chk_bit("fifo_drained_ready", rdy0, 1'b1);
`endif

    // Random requests and data against the model
    for (int i = 0; i < 2500; i++) begin
      tx_start = ($urandom_range(0, 3) == 0);
      data     = 8'($urandom);
      tick();
    end
    tx_start = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
